// File: rtl/branch_predictor_btb_pkg.sv
// Shared constants for the fetch-side branch predictor and its BTB.
package branch_predictor_btb_pkg;

  localparam int unsigned IDX_W_DEF = 4;
  localparam int unsigned PC_W_DEF  = 32;
  localparam int unsigned CNT_W     = 32;

  localparam logic [1:0] CTR_SNT   = 2'b00;
  localparam logic [1:0] CTR_WNT   = 2'b01;
  localparam logic [1:0] CTR_WT    = 2'b10;
  localparam logic [1:0] CTR_ST    = 2'b11;
  localparam logic [1:0] CTR_RST   = CTR_WNT;
  localparam logic [1:0] CTR_ALLOC = CTR_WT;

endpackage

// File: rtl/branch_predictor_btb_if.sv
// Prediction, resolution and perf-counter signals between pipeline and predictor.
interface branch_predictor_btb_if #(
  parameter int unsigned PC_W = 32
);
  logic [PC_W-1:0] if_pc;
  logic            pred_taken;
  logic [PC_W-1:0] pred_target;
  logic            upd_valid;
  logic [PC_W-1:0] upd_pc;
  logic            upd_taken;
  logic [PC_W-1:0] upd_target;
  logic            upd_pred_taken;
  logic [PC_W-1:0] upd_pred_target;
  logic            mispredict;
  logic [PC_W-1:0] redirect_pc;
  logic [31:0]     br_cnt;
  logic [31:0]     mis_cnt;

  modport master (
    output if_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken, upd_pred_target,
    input  pred_taken, pred_target, mispredict, redirect_pc, br_cnt, mis_cnt
  );

  modport slave (
    input  if_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken, upd_pred_target,
    output pred_taken, pred_target, mispredict, redirect_pc, br_cnt, mis_cnt
  );
endinterface

// File: rtl/branch_predictor_btb_bht_sat_ctr.sv
// Next-state logic for a 2-bit saturating taken/not-taken counter.
module bht_sat_ctr
  import branch_predictor_btb_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (taken) begin
      if (ctr != CTR_ST) ctr_next = ctr + 2'd1;
    end else begin
      if (ctr != CTR_SNT) ctr_next = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with 2-bit counters: zero-latency prediction, resolution
// write-back, mispredict/redirect generation and branch/mispredict counters.
module branch_predictor_btb
  import branch_predictor_btb_pkg::*;
#(
  parameter int unsigned IDX_W = IDX_W_DEF,
  parameter int unsigned PC_W  = PC_W_DEF
) (
  input logic                  clk,
  input logic                  rst,
  branch_predictor_btb_if.slave bus
);

  localparam int unsigned ENTRIES = 2 ** IDX_W;
  localparam int unsigned TAG_W   = PC_W - IDX_W - 2;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [PC_W-1:0]    target_q [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];
  logic [CNT_W-1:0]   br_cnt_q;
  logic [CNT_W-1:0]   mis_cnt_q;

  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic [TAG_W-1:0] rd_tag, wr_tag;
  logic             rd_hit, wr_hit;
  logic             pred_taken_c;
  logic             mispredict_c;
  logic [1:0]       ctr_next;

  assign rd_idx = bus.if_pc[IDX_W+1:2];
  assign rd_tag = bus.if_pc[PC_W-1:IDX_W+2];
  assign wr_idx = bus.upd_pc[IDX_W+1:2];
  assign wr_tag = bus.upd_pc[PC_W-1:IDX_W+2];

  // Prediction reads pre-update contents; no write-to-read bypass.
  assign rd_hit       = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign pred_taken_c = rd_hit && ctr_q[rd_idx][1];
  assign bus.pred_taken  = pred_taken_c;
  assign bus.pred_target = pred_taken_c ? target_q[rd_idx] : bus.if_pc + PC_W'(4);

  assign mispredict_c = bus.upd_valid &&
                        ((bus.upd_taken != bus.upd_pred_taken) ||
                         (bus.upd_taken && (bus.upd_target != bus.upd_pred_target)));
  assign bus.mispredict  = mispredict_c;
  assign bus.redirect_pc = bus.upd_taken ? bus.upd_target : bus.upd_pc + PC_W'(4);

  assign bus.br_cnt  = br_cnt_q;
  assign bus.mis_cnt = mis_cnt_q;

  assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

  bht_sat_ctr u_sat_ctr (
    .ctr      (ctr_q[wr_idx]),
    .taken    (bus.upd_taken),
    .ctr_next (ctr_next)
  );

  // Table write-back and perf counters; reset wins over a same-cycle update.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= '0;
      ctr_q     <= '{default: CTR_RST};
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else if (bus.upd_valid) begin
      br_cnt_q <= br_cnt_q + CNT_W'(1);
      if (mispredict_c) mis_cnt_q <= mis_cnt_q + CNT_W'(1);
      if (wr_hit) begin
        ctr_q[wr_idx] <= ctr_next;
        if (bus.upd_taken) target_q[wr_idx] <= bus.upd_target;
      end else if (bus.upd_taken) begin
        valid_q[wr_idx]  <= 1'b1;
        tag_q[wr_idx]    <= wr_tag;
        target_q[wr_idx] <= bus.upd_target;
        ctr_q[wr_idx]    <= CTR_ALLOC;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Directed scoreboard bench for branch_predictor_btb.
module tb_branch_predictor_btb;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_predictor_btb_if #(.PC_W(32)) bus ();

  branch_predictor_btb #(.IDX_W(4), .PC_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef enum int {K_PT, K_PTGT, K_MIS, K_RPC, K_BR, K_MC} kind_e;
  typedef struct {
    kind_e       kind;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  logic [31:0] exp_br = 0;
  logic [31:0] exp_mc = 0;

  task automatic push(kind_e k, logic [31:0] v, string n);
    exp_t e;
    e.kind = k;
    e.val  = v;
    e.name = n;
    sb.push_back(e);
  endtask

  task automatic check_all();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        K_PT:    obs = {31'b0, bus.pred_taken};
        K_PTGT:  obs = bus.pred_target;
        K_MIS:   obs = {31'b0, bus.mispredict};
        K_RPC:   obs = bus.redirect_pc;
        K_BR:    obs = bus.br_cnt;
        default: obs = bus.mis_cnt;
      endcase
      checks++;
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.name, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Prediction-only cycle: no update, check prediction and counters.
  task automatic probe(logic [31:0] pc, logic ept, logic [31:0] eptgt, string n);
    bus.if_pc     = pc;
    bus.upd_valid = 1'b0;
    #1;
    push(K_PT, {31'b0, ept}, {n, "_pt"});
    push(K_PTGT, eptgt, {n, "_ptgt"});
    push(K_MIS, 32'd0, {n, "_mis"});
    push(K_BR, exp_br, {n, "_br"});
    push(K_MC, exp_mc, {n, "_mc"});
    check_all();
  endtask

  // Resolution cycle: check same-cycle prediction and mispredict outputs, then clock it in.
  task automatic upd(logic [31:0] ifpc, logic [31:0] upc, logic tk, logic [31:0] tgt,
                     logic ptk, logic [31:0] ptgt, logic ept, logic [31:0] eptgt,
                     logic emis, logic [31:0] erpc, string n);
    bus.if_pc           = ifpc;
    bus.upd_valid       = 1'b1;
    bus.upd_pc          = upc;
    bus.upd_taken       = tk;
    bus.upd_target      = tgt;
    bus.upd_pred_taken  = ptk;
    bus.upd_pred_target = ptgt;
    #1;
    push(K_PT, {31'b0, ept}, {n, "_pt"});
    push(K_PTGT, eptgt, {n, "_ptgt"});
    push(K_MIS, {31'b0, emis}, {n, "_mis"});
    push(K_RPC, erpc, {n, "_rpc"});
    check_all();
    tick();
    exp_br = exp_br + 32'd1;
    if (emis) exp_mc = exp_mc + 32'd1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.if_pc = 32'h0; bus.upd_valid = 1'b0; bus.upd_pc = 32'h0; bus.upd_taken = 1'b0;
    bus.upd_target = 32'h0; bus.upd_pred_taken = 1'b0; bus.upd_pred_target = 32'h0;
    @(negedge clk);
    tick();
    rst = 1'b0;

    probe(32'h100, 1'b0, 32'h104, "reset");

    // Cold miss, also a same-cycle collision on the allocating index.
    upd(32'h100, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104, 1'b0, 32'h104, 1'b1, 32'h80, "cold");
    probe(32'h100, 1'b1, 32'h80, "cold_next");

    // Saturate upward: 10 -> 11 -> 11 -> 11.
    upd(32'h100, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80, 1'b1, 32'h80, 1'b0, 32'h80, "sat_t1");
    probe(32'h100, 1'b1, 32'h80, "sat_t1p");
    upd(32'h100, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80, 1'b1, 32'h80, 1'b0, 32'h80, "sat_t2");
    probe(32'h100, 1'b1, 32'h80, "sat_t2p");
    upd(32'h100, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80, 1'b1, 32'h80, 1'b0, 32'h80, "sat_t3");
    probe(32'h100, 1'b1, 32'h80, "sat_t3p");
    // Down: 11 -> 10 -> 01 -> 00.
    upd(32'h100, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80, 1'b1, 32'h80, 1'b1, 32'h104, "sat_n1");
    probe(32'h100, 1'b1, 32'h80, "sat_n1p");
    upd(32'h100, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80, 1'b1, 32'h80, 1'b1, 32'h104, "sat_n2");
    probe(32'h100, 1'b0, 32'h104, "sat_n2p");
    upd(32'h100, 32'h100, 1'b0, 32'h80, 1'b0, 32'h104, 1'b0, 32'h104, 1'b0, 32'h104, "sat_n3");
    upd(32'h100, 32'h100, 1'b0, 32'h80, 1'b0, 32'h104, 1'b0, 32'h104, 1'b0, 32'h104, "sat_n4");
    // From 00 one taken gives 01 (still not taken), a second gives 10.
    upd(32'h100, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104, 1'b0, 32'h104, 1'b1, 32'h80, "sat_up1");
    probe(32'h100, 1'b0, 32'h104, "sat_up1p");
    upd(32'h100, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104, 1'b0, 32'h104, 1'b1, 32'h80, "sat_up2");
    probe(32'h100, 1'b1, 32'h80, "sat_up2p");

    // Alias: 0x140 shares index 0 with 0x100 and evicts it.
    upd(32'h140, 32'h140, 1'b1, 32'h200, 1'b0, 32'h144, 1'b0, 32'h144, 1'b1, 32'h200, "alias");
    probe(32'h100, 1'b0, 32'h104, "alias_old");
    probe(32'h140, 1'b1, 32'h200, "alias_new");

    // Collision on a fresh index, then right-direction wrong-target.
    upd(32'h104, 32'h104, 1'b1, 32'h80, 1'b0, 32'h108, 1'b0, 32'h108, 1'b1, 32'h80, "coll");
    probe(32'h104, 1'b1, 32'h80, "coll_next");
    upd(32'h104, 32'h104, 1'b1, 32'h90, 1'b1, 32'h80, 1'b1, 32'h80, 1'b1, 32'h90, "wrong_tgt");
    probe(32'h104, 1'b1, 32'h90, "wrong_tgt_next");
    upd(32'h104, 32'h104, 1'b0, 32'h0, 1'b0, 32'h108, 1'b1, 32'h90, 1'b0, 32'h108, "nt_correct");
    probe(32'h104, 1'b1, 32'h90, "nt_correct_next");

    // PC+4 wrap on both the fetch and redirect paths.
    probe(32'hFFFF_FFFC, 1'b0, 32'h0, "wrap_pred");
    upd(32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, "wrap_rpc");
    probe(32'hFFFF_FFFC, 1'b0, 32'h0, "wrap_noalloc");

    // upd_valid=0 with allocating-looking data must change nothing.
    bus.upd_valid = 1'b0; bus.upd_pc = 32'h108; bus.upd_taken = 1'b1; bus.upd_target = 32'h300;
    bus.upd_pred_taken = 1'b0;
    tick();
    probe(32'h108, 1'b0, 32'h10C, "idle_upd");

    // Reset beats a same-cycle allocation.
    rst = 1'b1;
    bus.upd_valid = 1'b1; bus.upd_pc = 32'h100; bus.upd_taken = 1'b1; bus.upd_target = 32'h80;
    bus.upd_pred_taken = 1'b0; bus.upd_pred_target = 32'h104;
    tick();
    rst = 1'b0;
    exp_br = 0;
    exp_mc = 0;
    probe(32'h100, 1'b0, 32'h104, "rst_prio");
    probe(32'h104, 1'b0, 32'h108, "rst_clear");

    // Not-taken misses: no allocation; mis_cnt only when predicted taken.
    upd(32'h100, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80, 1'b0, 32'h104, 1'b1, 32'h104, "nt_miss_p1");
    probe(32'h100, 1'b0, 32'h104, "nt_miss_p1n");
    upd(32'h100, 32'h100, 1'b0, 32'h80, 1'b0, 32'h104, 1'b0, 32'h104, 1'b0, 32'h104, "nt_miss_p0");
    probe(32'h100, 1'b0, 32'h104, "nt_miss_p0n");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_predictor_btb.md
Name: branch_predictor_btb

Overview:
- Fetch-side counterpart to the branch comparator. It predicts taken/not-taken and the target for the IF-stage PC.
- The resolved outcome (comparator result plus computed target) is written back into a direct-mapped branch target buffer (BTB) with 2-bit saturating counters.
- It produces the mispredict/redirect signals that the pipeline uses to flush IF/ID.
- It also keeps a retired-branch counter and a mispredict counter for performance measurement.

Parameters:
- IDX_W, 4: index width; the table has 2**IDX_W entries.
- PC_W, 32: PC and target width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- if_pc  in  PC_W  PC currently being fetched
- pred_taken  out  1  prediction for if_pc
- pred_target  out  PC_W  next fetch PC
- upd_valid  in  1  a conditional branch resolves this cycle
- upd_pc  in  PC_W  PC of the resolving branch
- upd_taken  in  1  resolved outcome (comparator output)
- upd_target  in  PC_W  computed branch target
- upd_pred_taken  in  1  prediction carried down the pipe for this branch
- upd_pred_target  in  PC_W  predicted next PC carried down the pipe
- mispredict  out  1  flush request
- redirect_pc  out  PC_W  correct next PC when mispredict=1
- br_cnt  out  32  count of resolved branches
- mis_cnt  out  32  count of mispredicts

Behaviour:
Clock and reset:
- One clock, clk. Reset rst is synchronous and active-high.
- rst has priority over every update in the same cycle.

Entry format and indexing:
- Each entry holds: valid (1), tag (PC_W-IDX_W-2 bits), target (PC_W), ctr (2).
- index = pc[IDX_W+1:2]; tag = pc[PC_W-1:IDX_W+2].

Reset state:
- All valid bits = 0, all ctr = 2'b01 (weakly not-taken).
- br_cnt = 0, mis_cnt = 0.
- Combinational outputs after reset: pred_taken=0, pred_target=if_pc+4, mispredict=0 while upd_valid=0.

Prediction (combinational, zero latency):
- hit = valid[idx] & (tag[idx] == tag(if_pc)).
- pred_taken = hit & ctr[idx][1].
- pred_target = pred_taken ? target[idx] : if_pc+4.
- The +4 addition wraps modulo 2**PC_W.

Mispredict (combinational from the upd_* inputs):
- mispredict = upd_valid & ((upd_taken != upd_pred_taken) | (upd_taken & (upd_target != upd_pred_target))).
- redirect_pc = upd_taken ? upd_target : upd_pc+4. It is driven regardless of mispredict.

Table update (posedge clk, when upd_valid=1 and rst=0):
- Hit on upd_pc: ctr saturates upward on taken (11 stays 11) and downward on not-taken (00 stays 00). target is overwritten with upd_target only when taken. tag and valid are unchanged.
- Miss and taken: allocate (replacing any occupant): valid=1, tag, target=upd_target, ctr=2'b10.
- Miss and not-taken: table unchanged (no allocation).

Read/write collision:
- When if_pc and upd_pc map to the same index in the same cycle, the prediction uses the pre-update contents; there is no bypass.
- The new contents are visible from the next cycle.

Counters:
- br_cnt increments by 1 on every upd_valid cycle.
- mis_cnt increments by 1 when mispredict=1.
- Both wrap modulo 2**32.

Other rules:
- Reset asserted mid-stream: the table and counters clear at that edge, and any update presented in the same cycle is discarded.
- upd_valid=0: no state changes. All upd_* data inputs are don't-care.

Decomposition:
- Shared package constants: CTR_SNT=2'b00, CTR_WNT=2'b01, CTR_WT=2'b10, CTR_ST=2'b11, plus the reset value of ctr (CTR_WNT) and the allocation value (CTR_WT).
- One sub-module, bht_sat_ctr: combinational next-state for a 2-bit saturating counter. Inputs: ctr, taken. Output: ctr_next.
- The table storage and the perf counters stay in the top level.

Test Plan:
- Reset, then if_pc=0x100 -> pred_taken=0, pred_target=0x104, br_cnt=0, mis_cnt=0.
- Cold miss: upd_valid, upd_pc=0x100, taken=1, target=0x80, pred_taken=0 -> mispredict=1, redirect_pc=0x80. Next cycle, if_pc=0x100 -> pred_taken=1, pred_target=0x80, mis_cnt=1.
- Saturation: three taken updates on 0x100 give ctr=11. Then two not-taken updates -> ctr=01, pred_taken=0. A third not-taken -> ctr=00. Check there is no wrap at 11 or 00.
- Alias: entry allocated at 0x100. A taken update at 0x140 (same index with IDX_W=4, different tag) replaces it -> if_pc=0x100 misses (pred_target=0x104); if_pc=0x140 predicts 0x200 when target=0x200.
- Collision: if_pc=upd_pc=0x100 in the same cycle as a first allocation -> pred_taken=0 that cycle and 1 the next. A correct-direction, wrong-target update (pred_taken=1, taken=1, pred_target=0x80, target=0x90) -> mispredict=1, redirect_pc=0x90.
- Reset priority: rst=1 with upd_valid=1 allocating 0x100 -> the next cycle shows a miss at 0x100 and both counters at 0. A not-taken miss update -> no allocation, br_cnt increments, and mis_cnt increments only if upd_pred_taken=1.
